// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
// Holds the FSM state encoding, the op-kind encoding and the exception write constants.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_DIV  = 1'b0,
    OP_MULT = 1'b1
  } op_kind_t;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] MULT_EXC    = 32'd4;
  localparam logic [31:0] DIV_EXC     = 32'd5;

  // A mult flag wins when both kind flags are presented together.
  function automatic op_kind_t decode_kind(input logic is_mult);
    return is_mult ? OP_MULT : OP_DIV;
  endfunction

  function automatic logic [31:0] exc_code(input op_kind_t kind);
    return (kind == OP_MULT) ? MULT_EXC : DIV_EXC;
  endfunction

endpackage

// File: rtl/multdiv_busy_counter.sv
// Busy-cycle counter for the multdiv sequencer: clear/enable, with a terminal
// flag raised on the enabled cycle that brings the count up to TIMEOUT.
module multdiv_busy_counter #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Sequencer between execute and the iterative multiplier/divider cores.
// Optional: define MULTDIV_FASTPATH_EN to complete trivial mult/div ops without the cores.
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic        op_is_mult,
  input  logic        op_is_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  op_dest,
  output logic        stall,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        mult_or_div,
  input  logic [31:0] mult_result,
  input  logic        mult_exc,
  input  logic        mult_ready,
  input  logic [31:0] div_result,
  input  logic        div_exc,
  input  logic        div_ready,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        wb_exc,
  input  logic        wb_accept
);

  state_t      state_q, state_d;
  op_kind_t    kind_q;
  op_kind_t    kind_in;
  logic [4:0]  dest_q;
  logic        accept_op;
  logic        fast_hit;
  logic [31:0] fast_val;
  logic        sel_ready;
  logic        sel_exc;
  logic [31:0] sel_result;
  logic        cnt_clear;
  logic        cnt_en;
  logic        cnt_terminal;

  assign accept_op = op_valid && (op_is_mult || op_is_div);
  assign kind_in   = decode_kind(op_is_mult);

`ifdef MULTDIV_FASTPATH_EN
  // Multiplying by 0/1 or dividing by 1 needs no core; the answer is an operand or zero.
  always_comb begin
    fast_hit = 1'b0;
    fast_val = '0;
    if (kind_in == OP_MULT) begin
      fast_hit = (operand_a <= 32'd1) || (operand_b <= 32'd1);
      if (operand_a == '0 || operand_b == '0) fast_val = '0;
      else if (operand_a == 32'd1)            fast_val = operand_b;
      else                                    fast_val = operand_a;
    end else begin
      fast_hit = (operand_b == 32'd1);
      fast_val = operand_a;
    end
  end
`else
  assign fast_hit = 1'b0;
  assign fast_val = '0;
`endif

  // Only the core that was started may finish the op.
  assign sel_ready  = (kind_q == OP_MULT) ? mult_ready  : div_ready;
  assign sel_exc    = (kind_q == OP_MULT) ? mult_exc    : div_exc;
  assign sel_result = (kind_q == OP_MULT) ? mult_result : div_result;

  assign cnt_clear = (state_q == ST_START);
  assign cnt_en    = (state_q == ST_BUSY);

  multdiv_busy_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_busy_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_terminal)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_op) begin
          stall   = 1'b1;
          state_d = fast_hit ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        stall   = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (sel_ready || cnt_terminal) state_d = ST_DONE;
      end
      ST_DONE: begin
        stall = !wb_accept;
        if (wb_accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      kind_q    <= OP_DIV;
      dest_q    <= '0;
      core_a    <= '0;
      core_b    <= '0;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_data   <= '0;
      wb_dest   <= '0;
      wb_exc    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      if (state_q == ST_IDLE && accept_op) begin
        core_a <= operand_a;
        core_b <= operand_b;
        kind_q <= kind_in;
        dest_q <= op_dest;
        if (fast_hit) begin
          wb_data <= fast_val;
          wb_dest <= op_dest;
          wb_exc  <= 1'b0;
        end else begin
          ctrl_MULT <= (kind_in == OP_MULT);
          ctrl_DIV  <= (kind_in == OP_DIV);
        end
      end
      // A core result wins over a timeout landing on the same cycle.
      if (state_q == ST_BUSY && (sel_ready || cnt_terminal)) begin
        if (sel_ready && !sel_exc) begin
          wb_data <= sel_result;
          wb_dest <= dest_q;
          wb_exc  <= 1'b0;
        end else begin
          wb_data <= exc_code(kind_q);
          wb_dest <= RSTATUS_REG;
          wb_exc  <= 1'b1;
        end
      end
    end
  end

  assign mult_or_div = (kind_q == OP_MULT);
  assign wb_valid    = (state_q == ST_DONE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: timeline model of the op lifecycle
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        op_valid = 1'b0, op_is_mult = 1'b0, op_is_div = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [4:0]  op_dest = '0;
  logic        stall;
  logic [31:0] core_a, core_b;
  logic        ctrl_MULT, ctrl_DIV, mult_or_div;
  logic [31:0] mult_result = '0, div_result = '0;
  logic        mult_exc = 1'b0, mult_ready = 1'b0, div_exc = 1'b0, div_ready = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_exc;
  logic        wb_accept = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  int mult_pulses = 0;
  int div_pulses = 0;

  multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .op_valid(op_valid), .op_is_mult(op_is_mult), .op_is_div(op_is_div),
    .operand_a(operand_a), .operand_b(operand_b), .op_dest(op_dest),
    .stall(stall), .core_a(core_a), .core_b(core_b),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .mult_or_div(mult_or_div),
    .mult_result(mult_result), .mult_exc(mult_exc), .mult_ready(mult_ready),
    .div_result(div_result), .div_exc(div_exc), .div_ready(div_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_exc(wb_exc),
    .wb_accept(wb_accept)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Op lifecycle model: an op in flight has an age in cycles since it was accepted
  // (age 1 = start-pulse cycle, ages 2.. = busy cycles) and finishes once its result is known.
  bit        m_busy, m_done, m_mult;
  int        m_age;
  bit [31:0] m_a, m_b, e_data;
  bit [4:0]  m_dest, e_dest;
  bit        e_exc;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 0; m_done <= 0; m_mult <= 0; m_age <= 0;
      m_a <= 0; m_b <= 0; m_dest <= 0;
    end else if (!m_busy) begin
      if (op_valid && (op_is_mult || op_is_div)) begin
        m_busy <= 1; m_done <= 0; m_age <= 1;
        m_mult <= op_is_mult; m_a <= operand_a; m_b <= operand_b; m_dest <= op_dest;
`ifdef MULTDIV_FASTPATH_EN
        if (op_is_mult ? (operand_a <= 1 || operand_b <= 1) : (operand_b == 1)) begin
          m_done <= 1;
          e_data <= op_is_mult ? operand_a * operand_b : operand_a / operand_b;
          e_dest <= op_dest;
          e_exc  <= 0;
        end
`endif
      end
    end else if (m_done) begin
      if (wb_accept) begin m_busy <= 0; m_done <= 0; end
    end else begin
      m_age <= m_age + 1;
      if (m_age >= 2) begin
        if (m_mult ? mult_ready : div_ready) begin
          m_done <= 1;
          if (m_mult ? mult_exc : div_exc) begin
            e_data <= m_mult ? 32'd4 : 32'd5; e_dest <= 5'd30; e_exc <= 1;
          end else begin
            e_data <= m_mult ? mult_result : div_result; e_dest <= m_dest; e_exc <= 0;
          end
        end else if (m_age - 1 == TIMEOUT) begin
          m_done <= 1;
          e_data <= m_mult ? 32'd4 : 32'd5; e_dest <= 5'd30; e_exc <= 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (ctrl_MULT) mult_pulses++;
    if (ctrl_DIV)  div_pulses++;
    check("m_stall", stall, m_busy ? !(m_done && wb_accept) : (op_valid && (op_is_mult || op_is_div)));
    check("m_ctrl_mult", ctrl_MULT, m_busy && !m_done && m_age == 1 && m_mult);
    check("m_ctrl_div", ctrl_DIV, m_busy && !m_done && m_age == 1 && !m_mult);
    check("m_wb_valid", wb_valid, m_done);
    check("m_core_a", core_a, m_a);
    check("m_core_b", core_b, m_b);
    check("m_mult_or_div", mult_or_div, m_mult);
    if (m_done) begin
      check("m_wb_data", wb_data, e_data);
      check("m_wb_dest", wb_dest, e_dest);
      check("m_wb_exc", wb_exc, e_exc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit im, input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest);
    op_valid = 1; op_is_mult = im; op_is_div = id; operand_a = a; operand_b = b; op_dest = dest;
    t0 = cyc;
    tick(1);
    op_valid = 0; op_is_mult = 0; op_is_div = 0;
  endtask

  task automatic core_respond(input bit is_mult, input int delay, input logic [31:0] res, input bit exc);
    tick(delay);
    if (is_mult) begin mult_ready = 1; mult_result = res; mult_exc = exc; end
    else begin div_ready = 1; div_result = res; div_exc = exc; end
    tick(1);
    mult_ready = 0; mult_exc = 0; div_ready = 0; div_exc = 0;
  endtask

  task automatic wait_valid(input string name, input int budget, output int lat);
    int n = 0;
    while (!wb_valid && n < budget) begin tick(1); n++; end
    check({name, "_valid_seen"}, wb_valid, 1);
    lat = cyc - t0;
  endtask

  task automatic handoff(input int hold);
    tick(hold);
    wb_accept = 1;
    tick(1);
    wb_accept = 0;
  endtask

  task automatic check_wb(input string name, input logic [31:0] d, input logic [4:0] dst, input bit e);
    check({name, "_data"}, wb_data, d);
    check({name, "_dest"}, wb_dest, dst);
    check({name, "_exc"}, wb_exc, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0;
    #2 reset_n = 0;
    tick(2);
    check("rst_stall", stall, 0);
    check("rst_ctrl", {ctrl_MULT, ctrl_DIV, mult_or_div}, 0);
    check("rst_core_a", core_a, 0);
    check("rst_wb", {wb_valid, wb_exc, wb_dest}, 0);
    check("rst_wb_data", wb_data, 0);
    reset_n = 1;
    tick(1);

    // 1: mult 7 x -3, core ready 33 cycles after the pulse.
    p0 = mult_pulses;
    issue(1, 0, 32'd7, 32'hFFFF_FFFD, 5'd11);
    core_respond(1, 33, 32'hFFFF_FFEB, 0);
    wait_valid("t1", 10, lat);
    check("t1_latency", lat, 35);
    check("t1_pulses", mult_pulses - p0, 1);
    check_wb("t1", 32'hFFFF_FFEB, 5'd11, 0);
    handoff(0);

    // 2: overflow exception; a stale ready during the pulse cycle is ignored.
    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    mult_ready = 1; mult_result = 32'hDEAD; tick(1); mult_ready = 0;
    core_respond(1, 2, 32'h0, 1);
    wait_valid("t2", 10, lat);
    check("t2_latency", lat, 5);
    check_wb("t2", 32'd4, 5'd30, 1);
    handoff(0);

    // 3: divide by zero; mult_ready and a new op_valid during BUSY are ignored.
    p0 = div_pulses;
    issue(0, 1, 32'd100, 32'd0, 5'd12);
    tick(2);
    mult_ready = 1; mult_result = 32'h55;
    op_valid = 1; op_is_mult = 1; operand_a = 32'h999; operand_b = 32'h111;
    tick(1);
    mult_ready = 0; op_valid = 0; op_is_mult = 0;
    core_respond(0, 4, 32'h0, 1);
    wait_valid("t3", 10, lat);
    check("t3_latency", lat, 9);
    check("t3_pulses", div_pulses - p0, 1);
    check_wb("t3", 32'd5, 5'd30, 1);
    check("t3_core_a", core_a, 32'd100);
    handoff(0);

    // 4: mult never ready -> timeout after 40 busy cycles.
    issue(1, 0, 32'd5, 32'd6, 5'd3);
    wait_valid("t4", 60, lat);
    check("t4_latency", lat, 42);
    check_wb("t4", 32'd4, 5'd30, 1);
    handoff(1);

    // 5: reset during BUSY, then a clean div.
    issue(1, 0, 32'h11, 32'h22, 5'd4);
    tick(5);
    reset_n = 0;
    #1;
    check("t5_stall", stall, 0);
    check("t5_ctrl", {ctrl_MULT, ctrl_DIV, mult_or_div}, 0);
    check("t5_core", core_a | core_b, 0);
    check("t5_wb", {wb_valid, wb_exc, wb_dest}, 0);
    check("t5_wb_data", wb_data, 0);
    tick(2);
    reset_n = 1;
    tick(1);
    p0 = div_pulses;
    issue(0, 1, 32'd100, 32'd7, 5'd7);
    core_respond(0, 3, 32'd14, 0);
    wait_valid("t5", 10, lat);
    check("t5_latency", lat, 5);
    check("t5_pulses", div_pulses - p0, 1);
    check_wb("t5", 32'd14, 5'd7, 0);
    handoff(0);

    // 6: mult 1 x 0x1234, then hold off accept for 5 cycles.
    p0 = mult_pulses;
    issue(1, 0, 32'd1, 32'h1234, 5'd17);
`ifdef MULTDIV_FASTPATH_EN
    wait_valid("t6", 10, lat);
    check("t6_latency", lat, 1);
    check("t6_pulses", mult_pulses - p0, 0);
`else
    core_respond(1, 2, 32'h1234, 0);
    wait_valid("t6", 10, lat);
    check("t6_latency", lat, 4);
    check("t6_pulses", mult_pulses - p0, 1);
`endif
    check_wb("t6", 32'h1234, 5'd17, 0);
    for (int i = 0; i < 5; i++) begin
      check("t6_hold_data", wb_data, 32'h1234);
      check("t6_hold_stall", stall, 1);
      tick(1);
    end
    handoff(0);

    // 7: both kind flags set is a mult; neither set is ignored.
    issue(1, 1, 32'd3, 32'd5, 5'd21);
    check("t7_ctrl_mult", ctrl_MULT, 1);
    check("t7_mult_or_div", mult_or_div, 1);
    core_respond(1, 2, 32'd15, 0);
    wait_valid("t7", 10, lat);
    check_wb("t7", 32'd15, 5'd21, 0);
    handoff(0);
    issue(0, 0, 32'd8, 32'd9, 5'd1);
    check("t7_ignored", {ctrl_MULT, ctrl_DIV, wb_valid, stall}, 0);
    check("t7_core_a_kept", core_a, 32'd3);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
